// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if -- bundle between the multicycle MIPS main controller and its datapath.
//
// Signals:
//   op[5:0]      instruction opcode (instr[31:26]) from the instruction register
//   zero         ALU zero flag
//   mem_ready    memory access completes this cycle
//   iord         memory address select: 0 = PC, 1 = ALUOut
//   alu_src_a    ALU A select: 0 = PC, 1 = register A
//   alu_src_b    ALU B select: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op       00 = add, 01 = sub, 10 = funct-decoded
//   pc_src       00 = ALU result, 01 = ALUOut, 10 = jump target
//   mem_to_reg   register write data: 0 = ALUOut, 1 = MDR
//   reg_dst      write register: 0 = rt, 1 = rd
//   ir_write, mem_write, reg_write, pc_en   write strobes
//   illegal_op   one-cycle pulse on an unsupported opcode
//   dbg_state    current controller state code
//
// Modports: master = controller side, slave = datapath side.
interface mc_ctrl_if #(
  parameter int ST_W = 4
);
  logic [5:0]      op;
  logic            zero;
  logic            mem_ready;
  logic            iord;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_src;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            ir_write;
  logic            mem_write;
  logic            reg_write;
  logic            pc_en;
  logic            illegal_op;
  logic [ST_W-1:0] dbg_state;

  modport master (
    input  op, zero, mem_ready,
    output iord, alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, reg_dst,
           ir_write, mem_write, reg_write, pc_en, illegal_op, dbg_state
  );

  modport slave (
    output op, zero, mem_ready,
    input  iord, alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, reg_dst,
           ir_write, mem_write, reg_write, pc_en, illegal_op, dbg_state
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl -- main control FSM of the 32-bit multicycle MIPS datapath.
//
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives every datapath mux select and write strobe, and stalls on mem_ready.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mc_ctrl_if.master: op/zero/mem_ready in, selects/strobes/dbg_state out
//
// Parameters:
//   USE_MEM_READY  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: never wait
//   ST_W           state register / dbg_state width (must be at least 4)
module mc_main_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int ST_W          = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    FETCH  = ST_W'(0),
    DECODE = ST_W'(1),
    MEMADR = ST_W'(2),
    MEMRD  = ST_W'(3),
    MEMWB  = ST_W'(4),
    MEMWR  = ST_W'(5),
    EXEC   = ST_W'(6),
    ALUWB  = ST_W'(7),
    BRANCH = ST_W'(8),
    ADDIEX = ST_W'(9),
    ADDIWB = ST_W'(10),
    JUMP   = ST_W'(11)
  } state_t;

  // Purely state-decoded outputs; registered from the next state so they
  // come straight off flops and line up with the state they belong to.
  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       mem_write;
    logic       reg_write;
  } sel_t;

  localparam sel_t SEL_FETCH = '{iord: 1'b0, alu_src_a: 1'b0, alu_src_b: 2'b01,
                                 alu_op: 2'b00, pc_src: 2'b00, mem_to_reg: 1'b0,
                                 reg_dst: 1'b0, mem_write: 1'b0, reg_write: 1'b0};

  function automatic sel_t moore_dec(state_t s);
    sel_t d;
    d = '0;
    case (s)
      FETCH:  d = SEL_FETCH;
      DECODE: d.alu_src_b = 2'b11;               // branch target precompute
      MEMADR: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      MEMRD:  d.iord = 1'b1;
      MEMWB:  begin d.reg_write = 1'b1; d.mem_to_reg = 1'b1; end
      MEMWR:  begin d.iord = 1'b1; d.mem_write = 1'b1; end
      EXEC:   begin d.alu_src_a = 1'b1; d.alu_op = 2'b10; end
      ALUWB:  begin d.reg_write = 1'b1; d.reg_dst = 1'b1; end
      BRANCH: begin d.alu_src_a = 1'b1; d.alu_op = 2'b01; d.pc_src = 2'b01; end
      ADDIEX: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      ADDIWB: d.reg_write = 1'b1;
      JUMP:   d.pc_src = 2'b10;
      default: d = SEL_FETCH;
    endcase
    return d;
  endfunction

  state_t state_reg;
  state_t state_next;
  sel_t   sel_reg;
  logic   is_bne_reg;   // branch flavour, captured while op is still valid
  logic   is_sw_reg;    // load vs store, captured for the MEMADR decision
  logic   mr;
  logic   op_legal;

  assign mr = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_comb begin
    op_legal   = 1'b1;
    state_next = FETCH;
    case (bus.op)
      6'b100011, 6'b101011,
      6'b000000, 6'b000100,
      6'b000101, 6'b001000,
      6'b000010: op_legal = 1'b1;
      default:   op_legal = 1'b0;
    endcase

    case (state_reg)
      FETCH:  state_next = mr ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          6'b100011, 6'b101011: state_next = MEMADR;
          6'b000000:            state_next = EXEC;
          6'b000100, 6'b000101: state_next = BRANCH;
          6'b001000:            state_next = ADDIEX;
          6'b000010:            state_next = JUMP;
          default:              state_next = FETCH;
        endcase
      end
      MEMADR: state_next = is_sw_reg ? MEMWR : MEMRD;
      MEMRD:  state_next = mr ? MEMWB : MEMRD;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = mr ? FETCH : MEMWR;
      EXEC:   state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      ADDIEX: state_next = ADDIWB;
      ADDIWB: state_next = FETCH;
      JUMP:   state_next = FETCH;
      default: state_next = FETCH;   // codes 12..15 recover to FETCH
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      sel_reg    <= SEL_FETCH;
      is_bne_reg <= 1'b0;
      is_sw_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= moore_dec(state_next);
      if (state_reg == DECODE) begin
        is_bne_reg <= bus.op[0];   // 000101 vs 000100
        is_sw_reg  <= bus.op[3];   // 101011 vs 100011
      end
    end
  end

  assign bus.iord       = sel_reg.iord;
  assign bus.alu_src_a  = sel_reg.alu_src_a;
  assign bus.alu_src_b  = sel_reg.alu_src_b;
  assign bus.alu_op     = sel_reg.alu_op;
  assign bus.pc_src     = sel_reg.pc_src;
  assign bus.mem_to_reg = sel_reg.mem_to_reg;
  assign bus.reg_dst    = sel_reg.reg_dst;
  assign bus.mem_write  = sel_reg.mem_write;
  assign bus.reg_write  = sel_reg.reg_write;
  assign bus.dbg_state  = state_reg;

  // Input-qualified strobes. The rst_n gate keeps them low while reset is
  // held, since FETCH with mem_ready=1 would otherwise assert ir_write/pc_en.
  assign bus.ir_write   = rst_n && (state_reg == FETCH) && mr;
  assign bus.pc_en      = rst_n && (((state_reg == FETCH) && mr) ||
                                    ((state_reg == BRANCH) && (bus.zero ^ is_bne_reg)) ||
                                    (state_reg == JUMP));
  assign bus.illegal_op = rst_n && (state_reg == DECODE) && !op_legal;

endmodule

// File: tb/tb_mc_main_ctrl.sv
module tb_mc_main_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if #(.ST_W(4)) bus ();

  mc_main_ctrl #(.USE_MEM_READY(1'b1), .ST_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // {iord, a, b[1:0], aop[1:0], ps[1:0], mtr, rd, irw, mw, rw, pe, ill}
  wire [14:0] obs = {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                     bus.mem_to_reg, bus.reg_dst, bus.ir_write, bus.mem_write,
                     bus.reg_write, bus.pc_en, bus.illegal_op};

  // Output table transcribed from the controller's state description.
  function automatic logic [14:0] spec_out(int st, bit mr, bit z, bit bne, logic [5:0] op);
    logic iord = 0, a = 0, mtr = 0, rd = 0, irw = 0, mw = 0, rw = 0, pe = 0, ill = 0;
    logic [1:0] b = 2'b00, aop = 2'b00, ps = 2'b00;
    case (st)
      0:  begin b = 2'b01; irw = mr; pe = mr; end
      1:  begin
            b = 2'b11;
            ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                    op == 6'b000100 || op == 6'b000101 || op == 6'b001000 ||
                    op == 6'b000010);
          end
      2:  begin a = 1; b = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; mtr = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin a = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin a = 1; aop = 2'b01; ps = 2'b01; pe = bne ? !z : z; end
      9:  begin a = 1; b = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {iord, a, b, aop, ps, mtr, rd, irw, mw, rw, pe, ill};
  endfunction

  // Drive one cycle's inputs and move to the sampling point (posedge + 3).
  task automatic drive(bit mr, bit z, logic [5:0] op);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = op;
    #2;
  endtask

  task automatic push_all(string nm, int sts[], bit mrs[], logic [5:0] ops[], bit z, bit bne);
    for (int i = 0; i < sts.size(); i++)
      sb.push_back('{st: 4'(sts[i]), o: spec_out(sts[i], mrs[i], z, bne, ops[i])});
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('{st: 4'd0, o: 15'b0_0_01_00_00_0_0_0_0_0_0_0});
    drive(1'b1, 1'b0, 6'b000000);
    e = sb.pop_front();
    n_cmp++;
    if (bus.dbg_state !== e.st || obs !== e.o) begin
      n_err++;
      $display("FAIL reset_hold: got st=%0d out=%b, want st=%0d out=%b", bus.dbg_state, obs, e.st, e.o);
    end
    $display("reset_hold: st=%0d out=%b", bus.dbg_state, obs);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    int sts[] = '{0, 1, 6, 7};
    bit mrs[] = '{1, 1, 1, 1};
    logic [5:0] ops[] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000};
    exp_t e;
    push_all("rtype", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL rtype[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("rtype[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.dbg_state !== 4'd0) begin
      n_err++;
      $display("FAIL rtype_end: got st=%0d, want st=0", bus.dbg_state);
    end
  endtask

  task automatic test_lw_wait();
    int sts[] = '{0, 1, 2, 3, 3, 3, 4};
    bit mrs[] = '{1, 1, 1, 0, 0, 1, 1};
    logic [5:0] ops[] = '{6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011};
    exp_t e;
    int n_iord = 0, n_wb = 0;
    push_all("lw", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      if (bus.iord === 1'b1) n_iord++;
      if (bus.reg_write === 1'b1 && bus.mem_to_reg === 1'b1) n_wb++;
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL lw[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("lw[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.dbg_state !== 4'd0 || n_iord != 3 || n_wb != 1) begin
      n_err++;
      $display("FAIL lw_summary: got st=%0d iord=%0d wb=%0d, want st=0 iord=3 wb=1", bus.dbg_state, n_iord, n_wb);
    end
  endtask

  task automatic test_sw_wait();
    int sts[] = '{0, 1, 2, 5, 5};
    bit mrs[] = '{1, 1, 1, 0, 1};
    logic [5:0] ops[] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
    exp_t e;
    int n_mw = 0, n_rw = 0;
    push_all("sw", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      if (bus.mem_write === 1'b1) n_mw++;
      if (bus.reg_write === 1'b1) n_rw++;
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL sw[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("sw[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.dbg_state !== 4'd0 || n_mw != 2 || n_rw != 0) begin
      n_err++;
      $display("FAIL sw_summary: got st=%0d mem_write=%0d reg_write=%0d, want st=0 mem_write=2 reg_write=0", bus.dbg_state, n_mw, n_rw);
    end
  endtask

  task automatic test_branch(logic [5:0] op, bit z, bit want_pc_en);
    int sts[] = '{0, 1, 8};
    bit mrs[] = '{1, 1, 1};
    logic [5:0] ops[] = '{op, op, op};
    exp_t e;
    push_all("branch", sts, mrs, ops, z, op[0]);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], z, ops[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL branch_op%b_z%0d[%0d]: got st=%0d out=%b, want st=%0d out=%b", op, z, i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("branch_op%b_z%0d[%0d]: st=%0d out=%b", op, z, i, bus.dbg_state, obs);
      if (i == 2) begin
        n_cmp++;
        if (bus.pc_en !== want_pc_en || bus.pc_src !== 2'b01) begin
          n_err++;
          $display("FAIL branch_pc_en_op%b_z%0d: got pc_en=%0d pc_src=%b, want pc_en=%0d pc_src=01", op, z, bus.pc_en, bus.pc_src, want_pc_en);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int sts[] = '{0, 1};
    bit mrs[] = '{1, 1};
    logic [5:0] ops[] = '{6'b111111, 6'b111111};
    exp_t e;
    int n_ill = 0, n_wr = 0;
    push_all("illegal", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      if (bus.illegal_op === 1'b1) n_ill++;
      if (bus.mem_write === 1'b1 || bus.reg_write === 1'b1) n_wr++;
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL illegal[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("illegal[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.dbg_state !== 4'd0 || n_ill != 1 || n_wr != 0) begin
      n_err++;
      $display("FAIL illegal_summary: got st=%0d pulses=%0d writes=%0d, want st=0 pulses=1 writes=0", bus.dbg_state, n_ill, n_wr);
    end
  endtask

  // lw straight into addi, no idle cycle between instructions.
  task automatic test_back_to_back();
    int sts[] = '{0, 1, 2, 3, 4, 0, 1, 9, 10};
    bit mrs[] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [5:0] ops[] = '{6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011,
                          6'b001000, 6'b001000, 6'b001000, 6'b001000};
    exp_t e;
    push_all("b2b", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL b2b[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("b2b[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
  endtask

  // Reset in MEMWR while mem_write is high, then a jump after release.
  task automatic test_reset_mid();
    int sts[] = '{0, 1, 2, 5};
    bit mrs[] = '{1, 1, 1, 0};
    logic [5:0] ops[] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011};
    int jst[] = '{0, 1, 11};
    bit jmr[] = '{1, 1, 1};
    logic [5:0] jop[] = '{6'b000010, 6'b000010, 6'b000010};
    exp_t e;
    push_all("rstmid", sts, mrs, ops, 1'b0, 1'b0);
    for (int i = 0; i < sts.size(); i++) begin
      drive(mrs[i], 1'b0, ops[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL rstmid[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("rstmid[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      if (i < sts.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_write !== 1'b0 || bus.dbg_state !== 4'd0 || bus.ir_write !== 1'b0 || bus.pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: got mem_write=%0d st=%0d ir_write=%0d pc_en=%0d, want all 0",
               bus.mem_write, bus.dbg_state, bus.ir_write, bus.pc_en);
    end
    $display("rstmid_abort: mem_write=%0d st=%0d", bus.mem_write, bus.dbg_state);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_all("jump", jst, jmr, jop, 1'b0, 1'b0);
    for (int i = 0; i < jst.size(); i++) begin
      drive(jmr[i], 1'b0, jop[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.dbg_state !== e.st || obs !== e.o) begin
        n_err++;
        $display("FAIL jump[%0d]: got st=%0d out=%b, want st=%0d out=%b", i, bus.dbg_state, obs, e.st, e.o);
      end
      $display("jump[%0d]: st=%0d out=%b", i, bus.dbg_state, obs);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.dbg_state !== 4'd0) begin
      n_err++;
      $display("FAIL jump_end: got st=%0d, want st=0", bus.dbg_state);
    end
  endtask

  initial begin
    bus.op        = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000, want finish");
    $fatal(1, "timeout");
  end

endmodule
